// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the sync_memory block: controller state encoding,
// default geometry and the maximum supported read latency.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

  // Controller states. CLEAR is only reachable when MEM_CLEAR_EN is defined.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8192;
  localparam int RD_LAT_MAX = 4;

endpackage : mem_pkg

// File: rtl/mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// RD_LAT-stage shift register carrying {valid, err, data} for read responses.
// Stage 0 is loaded at the accepting edge, so the output appears RD_LAT cycles
// after acceptance. All stages clear asynchronously on rst so that no stale
// response can emerge after a reset.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   in_valid  read accepted this cycle
//   in_err    accepted read is out of range
//   in_data   array data sampled for the accepted read (0 when not valid)
//   out_valid response valid, RD_LAT cycles after acceptance
//   out_err   response error flag
//   out_data  response data
// -----------------------------------------------------------------------------
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] data_q [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_err;
      data_q[0]  <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];

endmodule : mem_rd_pipe

// File: rtl/sync_memory.sv
// -----------------------------------------------------------------------------
// sync_memory
// Single-port synchronous memory with a valid/ready request port and a
// valid-qualified, pipelined read response (latency RD_LAT, 1..4).
// Reads sample the array at the accepting edge (read-before-write).
// Out-of-range accesses (req_addr >= DEPTH) leave the array untouched and
// raise rsp_err: with the response for reads, one cycle after acceptance for
// writes.
//
// Optional feature, macro MEM_CLEAR_EN: when defined, reset enters a CLEAR
// sweep that writes zero to one word per cycle for DEPTH cycles; requests are
// refused (req_ready=0, busy=1) until it completes. When undefined, the block
// is ready immediately after reset and the array powers up undefined.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  request accepted when high together with req_valid
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  one-cycle pulse per accepted read
//   rsp_data   read data, 0 when rsp_valid is low
//   rsp_err    out-of-range access flag
//   busy       clear sweep in progress
// -----------------------------------------------------------------------------
module sync_memory
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $fatal(1, "sync_memory: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_fire;
  logic              wr_fire;
  logic              in_range;
  logic [DATA_W-1:0] rd_data;
  logic              wr_err_q;
  logic              pipe_err;
  logic              clear_we;
  logic [ADDR_W-1:0] clr_addr;

  assign rd_fire = req_valid & req_ready & ~req_we;
  assign wr_fire = req_valid & req_ready &  req_we;

  // Compare one bit wider so a power-of-two DEPTH does not truncate to zero.
  assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
`ifdef MEM_CLEAR_EN
  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_q;
  logic              busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Terminate on the last word, not on counter wrap: DEPTH need not
          // be a power of two.
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign clear_we  = (state == ST_CLEAR);
  assign clr_addr  = clr_cnt;
  assign req_ready = ready_q;
  assign busy      = busy_q;
`else
  assign clear_we  = 1'b0;
  assign clr_addr  = '0;
  assign req_ready = 1'b1;
  assign busy      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; clearing it is the job of the sweep, which
  // keeps this mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire && in_range) begin
      mem[req_addr] <= req_wdata;
    end
  end

  // Read data for the pipeline input; zero for idle cycles and bad addresses
  // so rsp_data is naturally 0 whenever rsp_valid is low.
  // NOTE: the default assignment first keeps this purely combinational.
  always_comb begin
    rd_data = '0;
    if (rd_fire && in_range) rd_data = mem[req_addr];
  end

  // Out-of-range write flag: one-cycle pulse after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_fire & ~in_range;
  end

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_err    (rd_fire & ~in_range),
    .in_data   (rd_data),
    .out_valid (rsp_valid),
    .out_err   (pipe_err),
    .out_data  (rsp_data)
  );

  assign rsp_err = pipe_err | wr_err_q;

endmodule : sync_memory
